aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Round sequencer for the byte-serial AES-128 encryption datapath. On `start` it issues the enable strobes that step SubBytes one byte per cycle, then ShiftRows, MixColumns and AddRoundKey. It counts rounds 0..10, skips MixColumns in round 10, and pulses `done` when the ciphertext is in the state register. It sits between the top-level load/unload logic and the sub/shift/mix/ark/key-expansion units.

## Interface
- No parameters; AES-128 fixed at 10 rounds and 16 bytes.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request a new encryption; sampled only in IDLE or DONE.
- `ld_state` output 1: load plaintext into the state register (INIT_ARK cycle).
- `sub_en` output 1: SubBytes enable for byte `byte_idx`.
- `byte_idx` output 4: byte under SubBytes, 0..15.
- `shift_en` output 1: one-cycle ShiftRows strobe.
- `mix_en` output 1: one-cycle MixColumns strobe.
- `ark_en` output 1: one-cycle AddRoundKey strobe.
- `key_step` output 1: advance key expansion to round key `round`.
- `round` output 4: current round, 0 (initial ARK) .. 10.
- `busy` output 1: high from INIT_ARK through the final ARK.
- `done` output 1: one-cycle pulse, ciphertext valid.

## Operation
- Moore FSM with states IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, DONE. All outputs decode from registered state, `round` and `byte_idx`.
- IDLE: all outputs 0. `start`=1 -> INIT_ARK; otherwise stay.
- INIT_ARK: `ld_state`=`ark_en`=1 with `round`=0. Next state SUB, with `round`<=1 and `byte_idx`<=0.
- SUB: `sub_en`=1.
  - `byte_idx` increments each cycle.
  - At `byte_idx`=15 the counter wraps to 0 and the FSM goes to SHIFT.
- SHIFT: `shift_en`=1 and `key_step`=1, so round key `round` is ready by ARK.
  - Next state is MIX if `round`<10, ARK if `round`=10.
- MIX: `mix_en`=1 -> ARK.
- ARK: `ark_en`=1.
  - If `round`=10 -> DONE.
  - Otherwise `round`<=`round`+1 and the FSM goes to SUB.
- DONE: `done`=1 and `busy`=0.
  - `start`=1 -> INIT_ARK (back-to-back operation).
  - Otherwise -> IDLE, with `round`<=0.
- `start` while `busy`=1 is ignored, with no queuing.
- At most one of `sub_en`/`shift_en`/`mix_en`/`ark_en` is high in any cycle. `ld_state` is high only together with `ark_en` in INIT_ARK.
- `byte_idx` is 0 in every state except SUB. `round` never exceeds 10.
- Reset at any time forces IDLE with every register and output 0. The operation in flight is abandoned and nothing is held over.

## Timing
- Reset values: all outputs 0; state IDLE; `round`=0; `byte_idx`=0.
- Cycle numbering: `start` is sampled high at the edge closing cycle 0.
  - Cycle 1: INIT_ARK.
  - Round r (1..9): SUB occupies cycles 2+19(r-1) .. 17+19(r-1); SHIFT, MIX and ARK follow at 18, 19 and 20 + 19(r-1).
  - Round 10: SUB cycles 173..188, SHIFT 189, ARK 190.
  - Cycle 191: DONE.
- Latency from the `start` sample to `done` is 191 cycles. `busy` is high for cycles 1..190 (190 cycles).
- With `start` held high in DONE, the next INIT_ARK follows immediately, giving a 191-cycle issue interval.

## Test plan
- **Reset:** assert `rst`=0 mid-SUB of round 4 -> all outputs 0 immediately. After release with `start`=0, stays IDLE with `done`=0 indefinitely.
- **Single run:** one-cycle `start` pulse. Required response:
  - `ld_state`/`ark_en` at cycle 1.
  - `sub_en` with `byte_idx` 0..15 in cycles 2..17, then `shift_en`@18, `mix_en`@19, `ark_en`@20 with `round`=1.
  - `done` exactly at cycle 191.
- **Strobe counts per run:** `sub_en`=160, `shift_en`=10, `mix_en`=9, `ark_en`=11, `key_step`=10, `ld_state`=1. No two datapath enables are ever high together.
- **Final round:** at cycle 189 `round`=10 and `shift_en`=1; cycle 190 is `ark_en`, not `mix_en`; `round` stays 10 until IDLE, then returns to 0.
- **Start while busy:** `start` high for cycles 0..50 -> single run, with `done` only at 191 and no restart before DONE.
- **Back-to-back:** `start` held high continuously -> `done` at cycles 191, 382, 573. `ld_state` is asserted at cycles 1, 192, 383.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the byte-serial AES-128 encryption datapath.
// Steps SubBytes per byte, then ShiftRows / MixColumns / AddRoundKey over rounds 0..10.
module aes_round_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ld_state,
  output logic       sub_en,
  output logic [3:0] byte_idx,
  output logic       shift_en,
  output logic       mix_en,
  output logic       ark_en,
  output logic       key_step,
  output logic [3:0] round,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_ARK,
    S_SUB,
    S_SHIFT,
    S_MIX,
    S_ARK,
    S_DONE
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [3:0] LAST_BYTE  = 4'd15;

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] byte_q, byte_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears all of it, abandoning any run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      byte_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      byte_q  <= byte_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    byte_d  = byte_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT_ARK;
          round_d = 4'd0;
        end
      end
      S_INIT_ARK: begin
        state_d = S_SUB;
        round_d = 4'd1;
        byte_d  = 4'd0;
      end
      S_SUB: begin
        if (byte_q == LAST_BYTE) begin
          byte_d  = 4'd0;
          state_d = S_SHIFT;
        end else begin
          byte_d = byte_q + 4'd1;
        end
      end
      S_SHIFT: begin
        state_d = (round_q == LAST_ROUND) ? S_ARK : S_MIX;
      end
      S_MIX: begin
        state_d = S_ARK;
      end
      S_ARK: begin
        if (round_q == LAST_ROUND) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = S_SUB;
        end
      end
      S_DONE: begin
        // round stays 10 while DONE is visible; it clears on the way out
        round_d = 4'd0;
        state_d = start ? S_INIT_ARK : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
        byte_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    ld_state = 1'b0;
    sub_en   = 1'b0;
    byte_idx = 4'd0;
    shift_en = 1'b0;
    mix_en   = 1'b0;
    ark_en   = 1'b0;
    key_step = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    round    = round_q;
    unique case (state_q)
      S_INIT_ARK: begin
        ld_state = 1'b1;
        ark_en   = 1'b1;
        busy     = 1'b1;
      end
      S_SUB: begin
        sub_en   = 1'b1;
        byte_idx = byte_q;
        busy     = 1'b1;
      end
      S_SHIFT: begin
        // key expansion advances here so round key `round` is ready by ARK
        shift_en = 1'b1;
        key_step = 1'b1;
        busy     = 1'b1;
      end
      S_MIX: begin
        mix_en = 1'b1;
        busy   = 1'b1;
      end
      S_ARK: begin
        ark_en = 1'b1;
        busy   = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed scenarios plus random start/reset
// traffic, compared every cycle against a cycle-position model of the round schedule.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       ld_state, sub_en, shift_en, mix_en, ark_en, key_step, busy, done;
  logic [3:0] byte_idx, round;

  aes_round_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ld_state(ld_state),
    .sub_en  (sub_en),
    .byte_idx(byte_idx),
    .shift_en(shift_en),
    .mix_en  (mix_en),
    .ark_en  (ark_en),
    .key_step(key_step),
    .round   (round),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: position within a run, 0 = idle, 1 = INIT_ARK cycle, 191 = DONE cycle
  int m_t = 0;
  int cyc = 0;
  int mode = 0;  // 1 = single-run targeted checks enabled
  int c_sub, c_shift, c_mix, c_ark, c_key, c_ld, c_done, done_at;
  int done_q[$];
  int ld_q[$];

  logic [15:0] outs;
  assign outs = {ld_state, sub_en, byte_idx, shift_en, mix_en, ark_en, key_step,
                 round, busy, done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d t=%0t", tag, got, exp, cyc, $time);
    end
  endtask

  // Expected outputs derived from the published cycle schedule:
  // rounds 1..9 take 19 cycles (16 SUB, SHIFT, MIX, ARK) starting at cycle 2,
  // round 10 takes 18 (no MIX), DONE lands on cycle 191.
  function automatic logic [15:0] exp_outs(input int t);
    logic       e_ld, e_sub, e_shift, e_mix, e_ark, e_key, e_busy, e_done;
    logic [3:0] e_idx, e_round;
    int k, r, p;
    {e_ld, e_sub, e_shift, e_mix, e_ark, e_key, e_busy, e_done} = '0;
    e_idx = 4'd0;
    e_round = 4'd0;
    if (t == 1) begin
      e_ld = 1'b1; e_ark = 1'b1; e_busy = 1'b1;
    end else if (t >= 2 && t <= 190) begin
      k = t - 2;
      r = k / 19 + 1;
      p = k % 19;
      e_busy  = 1'b1;
      e_round = 4'(r);
      if (p < 16) begin
        e_sub = 1'b1; e_idx = 4'(p);
      end else if (p == 16) begin
        e_shift = 1'b1; e_key = 1'b1;
      end else if (p == 17 && r < 10) begin
        e_mix = 1'b1;
      end else begin
        e_ark = 1'b1;
      end
    end else if (t == 191) begin
      e_done = 1'b1; e_round = 4'd10;
    end
    return {e_ld, e_sub, e_idx, e_shift, e_mix, e_ark, e_key, e_round, e_busy, e_done};
  endfunction

  task automatic clear_counts();
    c_sub = 0; c_shift = 0; c_mix = 0; c_ark = 0; c_key = 0; c_ld = 0; c_done = 0;
    done_at = -1;
    done_q.delete();
    ld_q.delete();
    cyc = 0;
  endtask

  // One clock: check outputs at the falling edge, drive start, then advance the model.
  task automatic step(input logic s);
    @(negedge clk);
    check("outs", outs, exp_outs(m_t));
    check("onehot", 32'($countones({sub_en, shift_en, mix_en, ark_en}) <= 1), 32'd1);
    c_sub   += int'(sub_en);
    c_shift += int'(shift_en);
    c_mix   += int'(mix_en);
    c_ark   += int'(ark_en);
    c_key   += int'(key_step);
    if (ld_state) begin c_ld++; ld_q.push_back(cyc); end
    if (done) begin
      c_done++;
      done_q.push_back(cyc);
      if (done_at < 0) done_at = cyc;
    end
    if (mode == 1) begin
      if (cyc == 1)   check("c1_ld", {ld_state, ark_en}, 2'b11);
      if (cyc == 18)  check("c18_shift", shift_en, 1'b1);
      if (cyc == 19)  check("c19_mix", mix_en, 1'b1);
      if (cyc == 20)  check("c20_ark_r1", {ark_en, round}, {1'b1, 4'd1});
      if (cyc == 189) check("c189_r10_shift", {shift_en, round}, {1'b1, 4'd10});
      if (cyc == 190) check("c190_ark_nomix", {ark_en, mix_en}, 2'b10);
      if (cyc == 192) check("idle_round0", round, 4'd0);
    end
    start = s;
    @(posedge clk);
    if (m_t == 0 || m_t == 191) m_t = s ? 1 : 0;
    else m_t = m_t + 1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_outs", outs, 16'h0);
    m_t = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int exp_done[3];
    int exp_ld[4];
    exp_done = '{191, 382, 573};
    exp_ld   = '{1, 192, 383, 574};

    #1;
    check("reset_outs", outs, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // single run with a one-cycle start pulse
    clear_counts();
    mode = 1;
    step(1'b1);
    repeat (199) step(1'b0);
    mode = 0;
    check("cnt_sub", c_sub, 160);
    check("cnt_shift", c_shift, 10);
    check("cnt_mix", c_mix, 9);
    check("cnt_ark", c_ark, 11);
    check("cnt_key", c_key, 10);
    check("cnt_ld", c_ld, 1);
    check("cnt_done", c_done, 1);
    check("done_at", done_at, 191);

    // start held through cycles 0..50 must not restart the run
    clear_counts();
    repeat (51) step(1'b1);
    repeat (149) step(1'b0);
    check("busy_start_done_cnt", c_done, 1);
    check("busy_start_done_at", done_at, 191);
    check("busy_start_ld_cnt", c_ld, 1);

    // back-to-back with start held high
    clear_counts();
    repeat (600) step(1'b1);
    check("b2b_done_n", done_q.size(), 3);
    check("b2b_ld_n", ld_q.size(), 4);
    foreach (exp_done[i])
      check("b2b_done_cyc", (i < done_q.size()) ? done_q[i] : -1, exp_done[i]);
    foreach (exp_ld[i])
      check("b2b_ld_cyc", (i < ld_q.size()) ? ld_q[i] : -1, exp_ld[i]);
    repeat (200) step(1'b0);

    // reset in the middle of round 4 SubBytes, then stay idle
    clear_counts();
    step(1'b1);
    repeat (63) step(1'b0);
    @(negedge clk);
    check("pre_rst_sub_r4", {sub_en, round}, {1'b1, 4'd4});
    do_reset();
    clear_counts();
    repeat (250) step(1'b0);
    check("post_rst_done_cnt", c_done, 0);
    check("post_rst_busy_cnt", c_sub + c_ark + c_ld, 0);

    // random traffic with occasional resets
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      else step(($urandom_range(0, 7) == 0) || (m_t > 150 && $urandom_range(0, 1) == 1));
    end
    repeat (5) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
